alu_req_sequencer: RTL and testbench
====================================

// Module: alu_req_sequencer
// PURPOSE
//  Shares the single combinational M-bit ALU between two requesters (0: core datapath, 1: debug/test port).
//  Round-robin arbitration, operand/opcode capture, ALU hold for a per-opcode settle time, result and NZVC capture.
//  Illegal opcodes and divide-by-zero are trapped. Sits between the requesters and the ALU; drives its a/b/ALUControl.
// PARAMETERS
//  M              4  operand/result width (matches ALU M)
//  SIMPLE_CYCLES  1  EXEC cycles for ADD/SUB/SLL/SRL/AND/OR/XOR/NOT (>=1)
//  MULDIV_CYCLES  2  EXEC cycles for MULT/DIV, covering the long combinational path (>=1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous reset, active low
//  req_valid   in   2      request valid, one bit per requester
//  req_ready   out  2      request accepted on this edge when valid&ready
//  req_op      in   [1:0][3:0]    ALUControl code per requester
//  req_a       in   [1:0][M-1:0]  operand a per requester
//  req_b       in   [1:0][M-1:0]  operand b per requester
//  rsp_valid   out  1      response valid
//  rsp_ready   in   1      response consumer ready
//  rsp_id      out  1      requester index of this response
//  rsp_result  out  M      captured result
//  rsp_flags   out  4      captured {N,Z,C,V}
//  rsp_err     out  1      1 = illegal op or DIV by zero
//  alu_a/alu_b out  M      to ALU a/b (from operand registers)
//  alu_ctrl    out  4      to ALU ALUControl (from opcode register)
//  alu_result  in   M      from ALU resultado
//  alu_z/n/v/c in   1      from ALU Z/N/V/C
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all regs and outputs 0, last_grant=1; req_ready=0 while rst_n=0.
//  In-flight op discarded by reset; no response is issued for it.
//  Opcodes: ADD=0 SUB=1 MULT=2 DIV=3 SLL=4 SRL=5 AND=6 OR=7 XOR=8 NOT=9; 10..15 illegal.
//  States: IDLE, EXEC, RESP.
//  IDLE: grant = sole valid requester; if both valid, the one != last_grant. req_ready=grant bit only.
//   Accept edge: latch op/a/b/id, last_grant<=id.
//   Legal op, not (DIV & b==0): ->EXEC, cnt<=cycles(op)-1.
//   Otherwise: ->RESP directly with err=1, result='1, flags=0; ALU result ignored.
//  EXEC: alu_* stable from regs; cnt decrements. Edge with cnt==0: capture alu_result and flags, err=0, ->RESP.
//   rsp_valid rises exactly cycles(op) edges after the accept edge.
//  RESP: rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready edge, then ->IDLE.
//   req_ready=0 in EXEC and RESP; no accept on the RESP-exit edge.
//  Throughput: one op per cycles(op)+2 clocks at best.
//  Width: no arithmetic in block other than cnt; result/flags passed unmodified from ALU.
//  req_* changes while not accepted: ignored. alu_* hold last op's values while in IDLE.
// STRUCTURE
//  alu_pkg: opcode localparams, OP_LAST=9, state_t enum, flag bit indices (N=3,Z=2,C=1,V=0).
//  Sub-module rr_arbiter2: inputs valid[1:0], last_grant, enable; outputs one-hot grant[1:0].
//  ALU instantiated by the parent, not inside this block.
// TESTING (M=4, ALU instantiated in bench)
//  1 Reset: rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, busy=0, alu_*=0.
//  2 Req0 ADD a=3 b=5 -> accept, 1 EXEC cycle, rsp_result=4'h8, flags N=1 Z=0, rsp_id=0, err=0.
//  3 Both valid, AND ops, twice back-to-back -> grants 0 then 1; next tie goes to 0.
//  4 Req1 DIV a=7 b=0 -> RESP on accept edge, err=1, result=4'hF, flags=0; op=4'hC -> same.
//  5 MULDIV_CYCLES=3, MULT a=2 b=3 -> rsp_valid 3 edges after accept, result=6; rsp_ready low 5 cycles -> rsp_* stable, req_ready=0.
//  6 rst_n pulsed low mid-EXEC -> no response; following SUB a=5 b=5 -> result=0, Z=1, err=0.

Source files
------------

// File: rtl/alu_req_sequencer_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the ALU request sequencer.
package alu_req_sequencer_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_LAST = OP_NOT;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

  // MULT/DIV get the longer hold because of the deep combinational path in the ALU.
  function automatic logic [CNT_W-1:0] exec_cycles(input logic [3:0] op,
                                                   input int simple_c,
                                                   input int muldiv_c);
    if (op == OP_MULT || op == OP_DIV) return CNT_W'(muldiv_c);
    return CNT_W'(simple_c);
  endfunction

endpackage

// File: rtl/alu_req_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: a tie goes to the requester that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (valid_i == 2'b11) grant_o = last_grant_i ? 2'b01 : 2'b10;
      else                  grant_o = valid_i;
    end
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one external combinational ALU between two requesters: arbitrate, capture operands,
// hold the ALU inputs for the opcode's settle time, then present a registered response.
module alu_req_sequencer
  import alu_req_sequencer_pkg::*;
#(
  parameter int M             = 4,
  parameter int SIMPLE_CYCLES = 1,
  parameter int MULDIV_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][3:0]  req_op_i,
  input  logic [1:0][M-1:0] req_a_i,
  input  logic [1:0][M-1:0] req_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [M-1:0]     rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic             rsp_err_o,
  output logic [M-1:0]     alu_a_o,
  output logic [M-1:0]     alu_b_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [M-1:0]     alu_result_i,
  input  logic             alu_z_i,
  input  logic             alu_n_i,
  input  logic             alu_v_i,
  input  logic             alu_c_i,
  output logic             busy_o
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [M-1:0]     a_q, b_q, result_q;
  logic [3:0]       flags_q;
  logic             id_q, err_q, last_grant_q;

  logic [1:0]       grant;
  logic             acc_id;
  logic [3:0]       sel_op;
  logic [M-1:0]     sel_a, sel_b;
  logic [3:0]       alu_flags;

  // Gating with rst_ni keeps ready low for the whole time reset is asserted.
  rr_arbiter2 u_arb (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant_q),
    .enable_i     ((state_q == ST_IDLE) && rst_ni),
    .grant_o      (grant)
  );

  assign acc_id = grant[1];
  assign sel_op = req_op_i[acc_id];
  assign sel_a  = req_a_i[acc_id];
  assign sel_b  = req_b_i[acc_id];

  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = alu_n_i;
    alu_flags[FLAG_Z] = alu_z_i;
    alu_flags[FLAG_C] = alu_c_i;
    alu_flags[FLAG_V] = alu_v_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      flags_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            op_q         <= sel_op;
            a_q          <= sel_a;
            b_q          <= sel_b;
            id_q         <= acc_id;
            last_grant_q <= acc_id;
            // Trapped ops skip the ALU entirely and answer straight away.
            if (is_legal(sel_op) && !(sel_op == OP_DIV && sel_b == '0)) begin
              state_q <= ST_EXEC;
              cnt_q   <= exec_cycles(sel_op, SIMPLE_CYCLES, MULDIV_CYCLES) - CNT_W'(1);
            end else begin
              state_q  <= ST_RESP;
              err_q    <= 1'b1;
              result_q <= '1;
              flags_q  <= '0;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            result_q <= alu_result_i;
            flags_q  <= alu_flags;
            err_q    <= 1'b0;
            state_q  <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = grant;
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign rsp_flags_o  = flags_q;
  assign rsp_err_o    = err_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_ctrl_o   = op_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer with a small behavioural 4-bit ALU attached.
module tb_alu_req_sequencer;

  localparam int M = 4;

  logic             clk;
  logic             rstN;
  logic [1:0]       reqValid;
  logic [1:0]       reqReady;
  logic [1:0][3:0]  reqOp;
  logic [1:0][M-1:0] reqA;
  logic [1:0][M-1:0] reqB;
  logic             rspValid;
  logic             rspReady;
  logic             rspId;
  logic [M-1:0]     rspResult;
  logic [3:0]       rspFlags;
  logic             rspErr;
  logic [M-1:0]     aluA, aluB, aluRes;
  logic [3:0]       aluCtrl;
  logic             aluZ, aluN, aluV, aluC;
  logic             busy;
  logic [M:0]       wide;

  int vectors = 0;
  int miscompares = 0;

  alu_req_sequencer #(.M(M), .SIMPLE_CYCLES(1), .MULDIV_CYCLES(3)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_op_i     (reqOp),
    .req_a_i      (reqA),
    .req_b_i      (reqB),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_id_o     (rspId),
    .rsp_result_o (rspResult),
    .rsp_flags_o  (rspFlags),
    .rsp_err_o    (rspErr),
    .alu_a_o      (aluA),
    .alu_b_o      (aluB),
    .alu_ctrl_o   (aluCtrl),
    .alu_result_i (aluRes),
    .alu_z_i      (aluZ),
    .alu_n_i      (aluN),
    .alu_v_i      (aluV),
    .alu_c_i      (aluC),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; C and V are only meaningful for ADD/SUB.
  always_comb begin
    wide   = '0;
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (aluCtrl)
      4'd0: begin
        wide   = {1'b0, aluA} + {1'b0, aluB};
        aluRes = wide[M-1:0];
        aluC   = wide[M];
        aluV   = (aluA[M-1] == aluB[M-1]) && (aluRes[M-1] != aluA[M-1]);
      end
      4'd1: begin
        wide   = {1'b0, aluA} + {1'b0, ~aluB} + (M+1)'(1);
        aluRes = wide[M-1:0];
        aluC   = wide[M];
        aluV   = (aluA[M-1] != aluB[M-1]) && (aluRes[M-1] != aluA[M-1]);
      end
      4'd2: aluRes = aluA * aluB;
      4'd3: aluRes = (aluB == '0) ? '0 : aluA / aluB;
      4'd4: aluRes = aluA << aluB;
      4'd5: aluRes = aluA >> aluB;
      4'd6: aluRes = aluA & aluB;
      4'd7: aluRes = aluA | aluB;
      4'd8: aluRes = aluA ^ aluB;
      4'd9: aluRes = ~aluA;
      default: aluRes = '0;
    endcase
    aluN = aluRes[M-1];
    aluZ = (aluRes == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request, confirms it is granted, and lets the accept edge pass.
  task automatic applyStimulus(input logic id, input logic [3:0] op,
                               input logic [M-1:0] a, input logic [M-1:0] b);
    reqOp[id]    = op;
    reqA[id]     = a;
    reqB[id]     = b;
    reqValid     = id ? 2'b10 : 2'b01;
    #1;
    checkOutput("grant", reqReady, id ? 2'b10 : 2'b01);
    step();
    reqValid = 2'b00;
  endtask

  task automatic drainResponse();
    rspReady = 1'b1;
    step();
    checkOutput("idle_after_rsp", {rspValid, busy}, 2'b00);
    rspReady = 1'b0;
  endtask

  initial begin
    rstN     = 1'b0;
    reqValid = 2'b11;
    reqOp    = '0;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b0;

    // Reset with both requesters asserting valid.
    #2;
    checkOutput("rst_ready", reqReady, 2'b00);
    checkOutput("rst_rsp_valid", rspValid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_alu", {aluA, aluB, aluCtrl}, 12'h000);
    step();
    step();
    reqValid = 2'b00;
    rstN     = 1'b1;
    step();

    // ADD 3+5 from requester 0.
    applyStimulus(1'b0, 4'd0, 4'd3, 4'd5);
    checkOutput("add_busy", {busy, rspValid}, 2'b10);
    checkOutput("add_alu_drive", {aluA, aluB, aluCtrl}, 12'h350);
    step();
    checkOutput("add_rsp_valid", rspValid, 1'b1);
    checkOutput("add_result", rspResult, 4'h8);
    checkOutput("add_flags", rspFlags, 4'b1001);
    checkOutput("add_id_err", {rspId, rspErr}, 2'b00);
    drainResponse();
    checkOutput("alu_hold_idle", {aluA, aluB, aluCtrl}, 12'h350);

    // DIV by zero is trapped on the accept edge.
    applyStimulus(1'b1, 4'd3, 4'd7, 4'd0);
    checkOutput("div0_rsp_valid", rspValid, 1'b1);
    checkOutput("div0_rsp", {rspId, rspErr, rspResult, rspFlags}, {1'b1, 1'b1, 4'hF, 4'h0});
    drainResponse();

    // Illegal opcode 0xC behaves the same.
    applyStimulus(1'b1, 4'hC, 4'd1, 4'd2);
    checkOutput("illegal_rsp_valid", rspValid, 1'b1);
    checkOutput("illegal_rsp", {rspId, rspErr, rspResult, rspFlags}, {1'b1, 1'b1, 4'hF, 4'h0});
    drainResponse();

    // Ties alternate: last grant was 1, so 0 wins first, then 1, then 0 again.
    reqOp[0]  = 4'd6; reqA[0] = 4'hC; reqB[0] = 4'hA;
    reqOp[1]  = 4'd6; reqA[1] = 4'hF; reqB[1] = 4'h3;
    reqValid  = 2'b11;
    #1;
    checkOutput("tie1_grant", reqReady, 2'b01);
    step();
    checkOutput("tie_exec_ready", reqReady, 2'b00);
    step();
    checkOutput("tie1_rsp", {rspValid, rspId, rspResult, rspFlags}, {1'b1, 1'b0, 4'h8, 4'b1000});
    checkOutput("tie_resp_ready", reqReady, 2'b00);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    checkOutput("tie_exit_no_accept", {busy, rspValid}, 2'b00);
    checkOutput("tie2_grant", reqReady, 2'b10);
    step();
    step();
    checkOutput("tie2_rsp", {rspValid, rspId, rspResult, rspFlags}, {1'b1, 1'b1, 4'h3, 4'b0000});
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    checkOutput("tie3_grant", reqReady, 2'b01);
    reqValid = 2'b00;

    // MULT takes three EXEC cycles; response then held under backpressure.
    applyStimulus(1'b0, 4'd2, 4'd2, 4'd3);
    checkOutput("mult_edge1", rspValid, 1'b0);
    step();
    checkOutput("mult_edge2", rspValid, 1'b0);
    step();
    checkOutput("mult_edge3_pre", rspValid, 1'b0);
    step();
    checkOutput("mult_rsp_valid", rspValid, 1'b1);
    checkOutput("mult_rsp", {rspId, rspErr, rspResult, rspFlags}, {1'b0, 1'b0, 4'h6, 4'b0000});
    reqValid = 2'b11;
    reqOp[0] = 4'd0; reqA[0] = 4'h1; reqB[0] = 4'h1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("mult_hold_rsp", {rspValid, rspId, rspErr, rspResult, rspFlags},
                  {1'b1, 1'b0, 1'b0, 4'h6, 4'b0000});
      checkOutput("mult_hold_ready", reqReady, 2'b00);
    end
    reqValid = 2'b00;
    drainResponse();

    // Reset mid-EXEC drops the operation with no response.
    applyStimulus(1'b0, 4'd2, 4'd3, 4'd3);
    step();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_state", {busy, rspValid}, 2'b00);
    checkOutput("midrst_alu", {aluA, aluB, aluCtrl}, 12'h000);
    step();
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("midrst_no_rsp", {busy, rspValid}, 2'b00);
    end

    // SUB 5-5 after the reset.
    applyStimulus(1'b0, 4'd1, 4'd5, 4'd5);
    step();
    checkOutput("sub_rsp_valid", rspValid, 1'b1);
    checkOutput("sub_rsp", {rspId, rspErr, rspResult, rspFlags}, {1'b0, 1'b0, 4'h0, 4'b0110});
    drainResponse();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
